// File: rtl/lgn_sequencer.sv
// Input-side sequencer for the LGN classifier: streams image bytes into the
// datapath shift register, waits for it to settle, then scans category sums for the winner.
module lgn_sequencer #(
   parameter int unsigned BYTES         = 98,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned CATEGORIES    = 10,
   parameter int unsigned SUM_W         = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   input  logic             flush,
   output logic             shift_en,
   output logic [7:0]       shift_data,
   output logic [3:0]       cat_sel,
   input  logic [SUM_W-1:0] cat_sum,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [3:0]       result_index,
   output logic [SUM_W-1:0] result_value,
   output logic             busy
);

   localparam int unsigned BCW = $clog2(BYTES + 1);

   typedef enum logic [1:0] {
      S_LOAD,
      S_SETTLE,
      S_SCAN,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
   logic [3:0]         settle_cnt_q, settle_cnt_d;
   logic [3:0]         scan_idx_q, scan_idx_d;
   logic [3:0]         best_idx_q, best_idx_d;
   logic [SUM_W-1:0]   best_val_q, best_val_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_LOAD;
         byte_cnt_q   <= '0;
         settle_cnt_q <= '0;
         scan_idx_q   <= '0;
         best_idx_q   <= '0;
         best_val_q   <= '0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         scan_idx_q   <= scan_idx_d;
         best_idx_q   <= best_idx_d;
         best_val_q   <= best_val_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      settle_cnt_d = settle_cnt_q;
      scan_idx_d   = scan_idx_q;
      best_idx_d   = best_idx_q;
      best_val_d   = best_val_q;
      in_ready     = 1'b0;
      shift_en     = 1'b0;
      cat_sel      = '0;
      result_valid = 1'b0;
      busy         = 1'b0;

      case (state_q)
         S_LOAD: begin
            in_ready = 1'b1;
            shift_en = in_valid & ~flush;
            // flush wins over a coincident byte, which is dropped
            if (flush) begin
               byte_cnt_d = '0;
            end else if (in_valid) begin
               if (byte_cnt_q == BCW'(BYTES - 1)) begin
                  state_d      = S_SETTLE;
                  byte_cnt_d   = '0;
                  settle_cnt_d = '0;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end
         end
         S_SETTLE: begin
            busy = 1'b1;
            if (settle_cnt_q == 4'(SETTLE_CYCLES - 1)) begin
               state_d    = S_SCAN;
               scan_idx_d = '0;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         S_SCAN: begin
            busy    = 1'b1;
            cat_sel = scan_idx_q;
            // strict compare so ties keep the lowest index
            if (scan_idx_q == '0) begin
               best_val_d = cat_sum;
               best_idx_d = '0;
            end else if (cat_sum > best_val_q) begin
               best_val_d = cat_sum;
               best_idx_d = scan_idx_q;
            end
            if (scan_idx_q == 4'(CATEGORIES - 1)) begin
               state_d = S_DONE;
            end else begin
               scan_idx_d = scan_idx_q + 1'b1;
            end
         end
         S_DONE: begin
            result_valid = 1'b1;
            if (result_ready) begin
               state_d = S_LOAD;
            end
         end
         default: state_d = S_LOAD;
      endcase

      if (reset) begin
         in_ready     = 1'b0;
         shift_en     = 1'b0;
         result_valid = 1'b0;
         busy         = 1'b0;
      end
   end

   assign shift_data   = in_data;
   assign result_index = best_idx_q;
   assign result_value = best_val_q;

endmodule
